// File: rtl/countdown_counter_pkg.sv
// Shared constants for the countdown counter and its prescaler.
// DEF_WIDTH: default datapath width; MODE_*: STOP_AT_ZERO values.
package countdown_counter_pkg;

  localparam int DEF_WIDTH = 32;

  localparam bit MODE_WRAP = 1'b0;
  localparam bit MODE_STOP = 1'b1;

endpackage

// File: rtl/step_prescaler.sv
// Clock-enable prescaler: pulses step once every `duration` enabled cycles.
// Ports: clk, reset (async high), enable, clear, duration -> step.
module step_prescaler
  import countdown_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] duration,
  output logic             step
);

  logic [WIDTH-1:0] div_cnt;
  logic             last;

  // >= rather than == so lowering duration mid-period cannot strand div_cnt
  // above the terminal value for a full 2^WIDTH wrap.
  assign last = (duration <= WIDTH'(1)) ||
                (div_cnt >= duration - WIDTH'(1));
  assign step = enable & last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (clear || step) begin
      div_cnt <= '0;
    end else if (enable) begin
      div_cnt <= div_cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/countdown_counter.sv
// Programmable down-counter with prescaled steps, wrap borrow or stop-at-0.
// Ports: clk, reset, enable, load, load_value, sup, duration -> number,
// borrow, zero, done.
module countdown_counter
  import countdown_counter_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter bit STOP_AT_ZERO = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] sup,
  input  logic [WIDTH-1:0] duration,
  output logic [WIDTH-1:0] number,
  output logic             borrow,
  output logic             zero,
  output logic             done
);

  logic             step;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] cnt_q;
  logic             borrow_q;
  logic             done_q;

  step_prescaler #(
    .WIDTH(WIDTH)
  ) u_presc (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .clear   (load),
    .duration(duration),
    .step    (step)
  );

  assign load_clamped = (load_value > sup) ? sup : load_value;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      borrow_q <= 1'b0;
      if (load) begin
        cnt_q  <= load_clamped;
        done_q <= 1'b0;
      end else if (step) begin
        if (cnt_q > sup) begin
          cnt_q <= sup;
        end else if (cnt_q != '0) begin
          cnt_q <= cnt_q - WIDTH'(1);
        end else if (STOP_AT_ZERO) begin
          done_q <= 1'b1;
        end else begin
          cnt_q    <= sup;
          borrow_q <= 1'b1;
        end
      end
    end
  end

  assign number = cnt_q;
  assign borrow = borrow_q;
  assign zero   = (cnt_q == '0);
  assign done   = done_q;

endmodule
